// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_tx serial transmitter.
//   state_e : FSM state encoding (IDLE/ACTIVE)
//   frame_t : 11-bit serial frame layout, MSB..LSB = stop, parity, data, start
//   FRAME_W / LAST_IDX / CNT_W : frame width, index of the stop bit, counter width
//   PAR_*   : parity_type encodings
package piso_pkg;

    localparam int unsigned FRAME_W  = 11;
    localparam int unsigned LAST_IDX = 10;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_ODD      = 2'b01;
    localparam logic [1:0] PAR_EVEN     = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    typedef struct packed {
        logic       stop;
        logic       par;
        logic [7:0] data;
        logic       start;
    } frame_t;

    localparam logic [FRAME_W-1:0] FRAME_IDLE = '1;

endpackage

// File: rtl/piso_frame_gen.sv
// Combinational frame builder: {stop=1, P, data_in, start=0}.
// For "none" parity types P is forced to 1 and acts as a second stop bit.
// Build option PISO_INT_PARITY_EN: P is computed from data_in (odd/even)
// and parity_bit is ignored; otherwise P is taken from parity_bit.
// Ports:
//   data_in     [7:0] in  byte to frame
//   parity_type [1:0] in  00/11 none, 01 odd, 10 even
//   parity_bit        in  externally computed parity bit
//   frame_man   [10:0] out frame built from the current inputs
module piso_frame_gen
    import piso_pkg::*;
(
    input  logic [7:0]         data_in,
    input  logic [1:0]         parity_type,
    input  logic               parity_bit,
    output logic [FRAME_W-1:0] frame_man
);

    logic   par_c;
    frame_t frame_c;

`ifdef PISO_INT_PARITY_EN
    logic unused_parity_bit;
    assign unused_parity_bit = parity_bit;
`endif

    // Parity selection and frame assembly
    always_comb begin
        par_c = 1'b1;
`ifdef PISO_INT_PARITY_EN
        if (parity_type == PAR_ODD) begin
            par_c = ~^data_in;
        end else if (parity_type == PAR_EVEN) begin
            par_c = ^data_in;
        end
`else
        if ((parity_type == PAR_ODD) || (parity_type == PAR_EVEN)) begin
            par_c = parity_bit;
        end
`endif
        frame_c = '{stop: 1'b1, par: par_c, data: data_in, start: 1'b0};
    end

    assign frame_man = frame_c;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter. Latches an 11-bit frame when send is
// seen in IDLE and shifts it out LSB first (start, D0..D7, P, stop), one bit
// per baud_clk cycle, then returns to IDLE with a one-cycle done_flag pulse.
// Build option PISO_INT_PARITY_EN selects internally computed parity.
// Ports:
//   baud_clk          in  bit-rate clock (rising edge)
//   reset             in  synchronous active-high reset
//   send              in  level request to transmit
//   data_in     [7:0] in  byte to transmit
//   parity_type [1:0] in  00/11 none, 01 odd, 10 even
//   parity_bit        in  external parity bit
//   data_tx           out serial line, idle high
//   active_flag       out frame being shifted
//   done_flag         out one-cycle pulse after the stop bit
//   frame_man  [10:0] out frame built from current inputs
//   frame_r    [10:0] out latched frame in flight
//   next_state        out FSM state (0 IDLE, 1 ACTIVE)
//   count_full        out last frame bit on data_tx
module piso_tx
    import piso_pkg::*;
(
    input  logic               baud_clk,
    input  logic               reset,
    input  logic               send,
    input  logic [7:0]         data_in,
    input  logic [1:0]         parity_type,
    input  logic               parity_bit,
    output logic               data_tx,
    output logic               active_flag,
    output logic               done_flag,
    output logic [FRAME_W-1:0] frame_man,
    output logic [FRAME_W-1:0] frame_r,
    output logic               next_state,
    output logic               count_full
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 done_q, done_d;
    logic                 tx_q, tx_d;
    logic                 full_q, full_d;

    piso_frame_gen u_frame_gen (
        .data_in     (data_in),
        .parity_type (parity_type),
        .parity_bit  (parity_bit),
        .frame_man   (frame_man)
    );

    // State and output registers
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            frame_q <= FRAME_IDLE;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
            full_q  <= full_d;
        end
    end

    // Next-state, counter and shifter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (send) begin
                    frame_d = frame_man;
                    cnt_d   = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cnt_q == CNT_W'(LAST_IDX)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
        // Registered line value follows the bit that will be selected next cycle
        tx_d   = (state_d == ACTIVE) ? frame_d[cnt_d] : 1'b1;
        full_d = (state_d == ACTIVE) && (cnt_d == CNT_W'(LAST_IDX));
    end

    assign data_tx     = tx_q;
    assign active_flag = (state_q == ACTIVE);
    assign next_state  = (state_q == ACTIVE);
    assign done_flag   = done_q;
    assign count_full  = full_q;
    assign frame_r     = frame_q;

endmodule

// File: tb/tb_piso_tx.sv
module tb_piso_tx;

    logic        baud_clk = 1'b0;
    logic        reset    = 1'b1;
    logic        send     = 1'b0;
    logic [7:0]  data_in  = 8'h00;
    logic [1:0]  parity_type = 2'b00;
    logic        parity_bit  = 1'b0;
    logic        data_tx, active_flag, done_flag, next_state, count_full;
    logic [10:0] frame_man, frame_r;

    int pass_cnt  = 0;
    int total_cnt = 0;

    piso_tx dut (
        .baud_clk    (baud_clk),
        .reset       (reset),
        .send        (send),
        .data_in     (data_in),
        .parity_type (parity_type),
        .parity_bit  (parity_bit),
        .data_tx     (data_tx),
        .active_flag (active_flag),
        .done_flag   (done_flag),
        .frame_man   (frame_man),
        .frame_r     (frame_r),
        .next_state  (next_state),
        .count_full  (count_full)
    );

    always #5 baud_clk = ~baud_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference frame from the rules: stop*1024 + P*512 + data*2 + start(0)
    function automatic int ref_frame(input logic [7:0] d, input logic [1:0] pt, input logic pb);
        int p;
        p = 1;
`ifdef PISO_INT_PARITY_EN
        if (pt == 2'b01) p = ($countones(d) % 2 == 0) ? 1 : 0;
        if (pt == 2'b10) p = $countones(d) % 2;
`else
        if (pt == 2'b01 || pt == 2'b10) p = int'(pb);
`endif
        return 1024 + p * 512 + int'(d) * 2;
    endfunction

    // Behavioural model: position in frame (-1 = idle line), latched frame, done pulse
    int m_pos   = -1;
    int m_frame = 'h7FF;
    bit m_done  = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge baud_clk) begin
        if (reset) begin
            m_pos = -1; m_frame = 'h7FF; m_done = 1'b0; m_valid = 1'b1;
        end else if (m_pos < 0) begin
            m_done = 1'b0;
            if (send) begin
                m_frame = ref_frame(data_in, parity_type, parity_bit);
                m_pos   = 0;
            end
        end else if (m_pos == 10) begin
            m_pos = -1; m_done = 1'b1;
        end else begin
            m_pos++; m_done = 1'b0;
        end
    end

    // Per-cycle comparison against the model
    always @(posedge baud_clk) begin
        #1;
        if (m_valid) begin
            chk("data_tx",     32'(data_tx),     (m_pos < 0) ? 32'd1 : 32'((m_frame >> m_pos) & 1));
            chk("active_flag", 32'(active_flag), 32'(m_pos >= 0));
            chk("next_state",  32'(next_state),  32'(m_pos >= 0));
            chk("count_full",  32'(count_full),  32'(m_pos == 10));
            chk("done_flag",   32'(done_flag),   32'(m_done));
            chk("frame_r",     32'(frame_r),     32'(m_frame));
            chk("frame_man",   32'(frame_man),   32'(ref_frame(data_in, parity_type, parity_bit)));
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (active_flag !== 1'b0 && n < 20) begin
            @(negedge baud_clk);
            n++;
        end
        chk("idle_timeout", 32'(active_flag), 32'd0);
    endtask

    initial begin
        logic [10:0] seq;
        logic [10:0] exp_seq;
        int act_n, done_n, idle_n, full_n;

        // Reset held for 5 cycles
        repeat (5) @(negedge baud_clk);
        chk("rst_data_tx", 32'(data_tx), 32'd1);
        chk("rst_active",  32'(active_flag), 32'd0);
        chk("rst_done",    32'(done_flag), 32'd0);
        chk("rst_frame_r", 32'(frame_r), 32'h7FF);
        chk("rst_full",    32'(count_full), 32'd0);
        reset = 1'b0;
        @(negedge baud_clk);

        // Odd parity, external P=0, data 4A, single send pulse
        parity_type = 2'b01; parity_bit = 1'b0; data_in = 8'h4A;
        #1 chk("fm_4A_odd", 32'(frame_man), 32'h494);
        send = 1'b1;
        act_n = 0; done_n = 0; seq = '0;
        for (int s = 0; s < 14; s++) begin
            @(negedge baud_clk);
            send = 1'b0;
            if (s < 11) seq[s] = data_tx;
            if (s == 0) chk("fr_4A_odd", 32'(frame_r), 32'h494);
            act_n += int'(active_flag);
            done_n += int'(done_flag);
        end
        exp_seq = 11'b10010010100;
        chk("seq_4A", 32'(seq), 32'(exp_seq));
        chk("active_cycles", 32'(act_n), 32'd11);
        chk("done_pulses", 32'(done_n), 32'd1);

        // Frame builder under the other parity types
        parity_type = 2'b10; parity_bit = 1'b1; data_in = 8'h4A;
        #1 chk("fm_4A_even", 32'(frame_man), 32'h694);
        parity_type = 2'b00; parity_bit = 1'b0;
        #1 chk("fm_4A_none", 32'(frame_man), 32'h694);
        parity_type = 2'b11; data_in = 8'h5A;
        #1 chk("fm_5A_none3", 32'(frame_man), 32'h6B4);
`ifdef PISO_INT_PARITY_EN
        parity_type = 2'b01; parity_bit = 1'b1; data_in = 8'h4A;
        #1 chk("fm_int_odd", 32'(frame_man), 32'h494);
`endif

        // send held high: 3 back-to-back frames in 36 cycles
        @(negedge baud_clk);
        send = 1'b1;
        idle_n = 0; done_n = 0; full_n = 0;
        for (int s = 0; s < 36; s++) begin
            @(negedge baud_clk);
            idle_n += int'(!active_flag);
            done_n += int'(done_flag);
            full_n += int'(count_full);
            if (count_full) chk("stop_bit_high", 32'(data_tx), 32'd1);
        end
        chk("held_idle_cycles", 32'(idle_n), 32'd3);
        chk("held_done_pulses", 32'(done_n), 32'd3);
        chk("held_full_cycles", 32'(full_n), 32'd3);
        send = 1'b0;
        wait_idle();

        // Mid-frame input change, then reset at bit 5
        parity_type = 2'b01; parity_bit = 1'b0; data_in = 8'h4A;
        send = 1'b1;
        for (int s = 0; s < 6; s++) begin
            @(negedge baud_clk);
            if (s == 0) send = 1'b0;
            if (s == 2) begin data_in = 8'hFF; parity_type = 2'b10; parity_bit = 1'b1; end
        end
        chk("mid_frame_r", 32'(frame_r), 32'h494);
        chk("mid_bit5", 32'(data_tx), 32'd0);
        reset = 1'b1;
        @(negedge baud_clk);
        chk("abort_data_tx", 32'(data_tx), 32'd1);
        chk("abort_active",  32'(active_flag), 32'd0);
        chk("abort_frame_r", 32'(frame_r), 32'h7FF);
        reset = 1'b0;

        // Randomized traffic, model-checked every cycle
        for (int c = 0; c < 600; c++) begin
            @(negedge baud_clk);
            send        = ($urandom_range(0, 2) == 0);
            data_in     = 8'($urandom);
            parity_type = 2'($urandom);
            parity_bit  = 1'($urandom);
            reset       = ($urandom_range(0, 59) == 0);
        end
        reset = 1'b0; send = 1'b0;
        repeat (14) @(negedge baud_clk);
        chk("end_idle", 32'(active_flag), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
